// File: rtl/decode_stage.sv
// RV32I/E decode stage: combinational decode, busy-bit RAW interlock and a
// BUF_DEPTH-entry output FIFO toward execute.
package decode_pkg;
    typedef logic [6:0] opcode_t;
    typedef enum logic [1:0] {
        UNSET              = 2'd0,
        REGISTER_OPERATION = 2'd1,
        MEMORY_ACCESS      = 2'd2,
        BRANCH             = 2'd3
    } alu_op_t;

    localparam opcode_t OP_R      = 7'h33;
    localparam opcode_t OP_IMM    = 7'h13;
    localparam opcode_t OP_LOAD   = 7'h03;
    localparam opcode_t OP_JALR   = 7'h67;
    localparam opcode_t OP_STORE  = 7'h23;
    localparam opcode_t OP_BRANCH = 7'h63;
    localparam opcode_t OP_LUI    = 7'h37;
    localparam opcode_t OP_AUIPC  = 7'h17;
    localparam opcode_t OP_JAL    = 7'h6F;
endpackage

module decode_stage
    import decode_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  NUM_REGS  = 32,
    parameter int  BUF_DEPTH = 2,
    localparam int RA_W      = $clog2(NUM_REGS)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_instr,
    input  logic [XLEN-1:0] i_in_pc,
    input  logic            i_wb_valid,
    input  logic [RA_W-1:0] i_wb_rd,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_pc,
    output opcode_t         o_out_opcode,
    output logic [2:0]      o_out_funct3,
    output logic [6:0]      o_out_funct7,
    output logic [RA_W-1:0] o_out_rd,
    output logic [RA_W-1:0] o_out_rs1,
    output logic [RA_W-1:0] o_out_rs2,
    output logic [XLEN-1:0] o_out_imm,
    output alu_op_t         o_out_alu_op,
    output logic            o_out_illegal
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        opcode_t         opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [XLEN-1:0] imm;
        alu_op_t         alu_op;
        logic            illegal;
    } entry_t;

    entry_t             w_dec, w_head, w_out;
    logic [4:0]         w_f_rd, w_f_rs1, w_f_rs2;
    logic               w_use_rd, w_use_rs1, w_use_rs2, w_known, w_bad_reg;
    logic [31:0]        w_imm32;
    logic               w_hazard, w_full, w_push, w_pop;
    logic [NUM_REGS-1:0] r_busy, w_busy_nxt;
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [CNT_W-1:0]   r_count;
    entry_t             r_mem [BUF_DEPTH];

    assign w_f_rd  = i_in_instr[11:7];
    assign w_f_rs1 = i_in_instr[19:15];
    assign w_f_rs2 = i_in_instr[24:20];

    always_comb begin
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_known   = 1'b1;
        w_imm32   = '0;
        w_dec     = '0;
        w_dec.pc     = i_in_pc;
        w_dec.opcode = i_in_instr[6:0];
        unique case (i_in_instr[6:0])
            OP_R: begin
                {w_use_rd, w_use_rs1, w_use_rs2} = 3'b111;
                w_dec.funct3 = i_in_instr[14:12];
                w_dec.funct7 = i_in_instr[31:25];
                w_dec.alu_op = REGISTER_OPERATION;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                {w_use_rd, w_use_rs1} = 2'b11;
                w_dec.funct3 = i_in_instr[14:12];
                w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
                if (i_in_instr[6:0] == OP_LOAD) w_dec.alu_op = MEMORY_ACCESS;
            end
            OP_STORE: begin
                {w_use_rs1, w_use_rs2} = 2'b11;
                w_dec.funct3 = i_in_instr[14:12];
                w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
                w_dec.alu_op = MEMORY_ACCESS;
            end
            OP_BRANCH: begin
                {w_use_rs1, w_use_rs2} = 2'b11;
                w_dec.funct3 = i_in_instr[14:12];
                w_imm32 = {{19{i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                           i_in_instr[30:25], i_in_instr[11:8], 1'b0};
                w_dec.alu_op = BRANCH;
            end
            OP_LUI, OP_AUIPC: begin
                w_use_rd = 1'b1;
                w_imm32  = {i_in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                w_use_rd = 1'b1;
                w_imm32  = {{11{i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                            i_in_instr[20], i_in_instr[30:21], 1'b0};
            end
            default: w_known = 1'b0;
        endcase

        // RV32E: any referenced register above the implemented range traps
        w_bad_reg = (w_use_rd  && (int'(w_f_rd)  >= NUM_REGS)) ||
                    (w_use_rs1 && (int'(w_f_rs1) >= NUM_REGS)) ||
                    (w_use_rs2 && (int'(w_f_rs2) >= NUM_REGS));
        w_dec.illegal = !w_known || (i_in_instr[1:0] != 2'b11) || w_bad_reg;
        w_dec.imm     = XLEN'($signed(w_imm32));
        if (!w_dec.illegal) begin
            if (w_use_rd)  w_dec.rd  = w_f_rd[RA_W-1:0];
            if (w_use_rs1) w_dec.rs1 = w_f_rs1[RA_W-1:0];
            if (w_use_rs2) w_dec.rs2 = w_f_rs2[RA_W-1:0];
        end
    end

    // Unused/illegal source fields are already zero, so they never interlock
    assign w_hazard =
        ((w_dec.rs1 != '0) && r_busy[w_dec.rs1] && !(i_wb_valid && (i_wb_rd == w_dec.rs1))) ||
        ((w_dec.rs2 != '0) && r_busy[w_dec.rs2] && !(i_wb_valid && (i_wb_rd == w_dec.rs2)));

    assign w_full      = (r_count == CNT_FULL);
    assign o_in_ready  = !i_reset && !i_flush && !w_full && !w_hazard;
    assign w_push      = i_in_valid && o_in_ready;
    assign o_out_valid = !i_reset && (r_count != '0);
    assign w_pop       = o_out_valid && i_out_ready;

    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wb_valid) w_busy_nxt[i_wb_rd] = 1'b0;
        if (w_push && (w_dec.rd != '0)) w_busy_nxt[w_dec.rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_busy  <= '0;
        end else begin
            if (w_push) r_wptr <= f_inc(r_wptr);
            if (w_pop)  r_rptr <= f_inc(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= w_dec;
    end

    assign w_head = r_mem[r_rptr];
    assign w_out  = o_out_valid ? w_head : '0;

    assign o_out_pc      = w_out.pc;
    assign o_out_opcode  = w_out.opcode;
    assign o_out_funct3  = w_out.funct3;
    assign o_out_funct7  = w_out.funct7;
    assign o_out_rd      = w_out.rd;
    assign o_out_rs1     = w_out.rs1;
    assign o_out_rs2     = w_out.rs2;
    assign o_out_imm     = w_out.imm;
    assign o_out_alu_op  = w_out.alu_op;
    assign o_out_illegal = w_out.illegal;
endmodule
